// File: rtl/hci_tcdm_bank_responder.sv
// ============================================================================
//  Module   : hci_tcdm_bank_responder
//  Brief    : Single-bank TCDM responder model for HCI initiators. Byte-enabled
//             word memory with latency-1 responses, optional pseudo-random
//             grant stalls, and saturating read/write/stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hci_tcdm_bank_responder #(
  parameter int unsigned DW        = 32,
  parameter int unsigned BW        = 8,
  parameter int unsigned BANK_SIZE = 2048,
  parameter int unsigned AW        = $clog2(BANK_SIZE),
  parameter int unsigned IW        = 10,
  parameter int unsigned STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [DW-1:0]    data_i,
  input  logic [IW-1:0]    id_i,
  output logic             r_valid_o,
  output logic [DW-1:0]    r_data_o,
  output logic [IW-1:0]    r_id_o,
  output logic [31:0]      n_rd_o,
  output logic [31:0]      n_wr_o,
  output logic [31:0]      n_stall_o
);

  localparam int unsigned c_NUM_LANES = DW / BW;
  localparam int unsigned c_OFF_BITS  = $clog2(c_NUM_LANES);
  localparam int unsigned c_NUM_WORDS = BANK_SIZE / c_NUM_LANES;
  localparam int unsigned c_IDX_W     = AW - c_OFF_BITS;
  localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

  logic [DW-1:0]      r_mem [c_NUM_WORDS];
  logic               r_valid;
  logic [DW-1:0]      r_data;
  logic [IW-1:0]      r_id;
  logic [31:0]        r_n_rd;
  logic [31:0]        r_n_wr;
  logic [31:0]        r_n_stall;

  logic               w_lfsr_ok;
  logic               w_txn;
  logic [c_IDX_W-1:0] w_idx;

  // Byte-offset bits inside a word do not select storage.
  assign w_idx = add_i[AW-1:c_OFF_BITS];

  // Grant is combinational; clear always blocks it, the LFSR may also stall it.
  assign gnt_o = req_i & ~clear_i & w_lfsr_ok;

  // Reset does not gate the grant, but nothing is committed while it is held.
  assign w_txn = req_i & gnt_o & rst_ni;

  generate
    if (STALL_EN != 0) begin : g_stall
      logic [15:0] r_lfsr;
      logic        w_fb;

      // Fibonacci taps x^16+x^14+x^13+x^11+1 in right-shift form.
      assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

      // Free-running LFSR, reseeded by reset and by clear.
      always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
          r_lfsr <= LFSR_SEED;
        end else begin
          r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
      end

      assign w_lfsr_ok = (r_lfsr[1:0] != 2'b00);
    end else begin : g_no_stall
      assign w_lfsr_ok = 1'b1;
    end
  endgenerate

  // Byte-lane write into storage; memory is intentionally never reset.
  always_ff @(posedge clk_i) begin
    if (w_txn && !wen_i) begin
      for (int i = 0; i < c_NUM_LANES; i++) begin
        if (be_i[i]) begin
          r_mem[w_idx][i*BW +: BW] <= data_i[i*BW +: BW];
        end
      end
    end
  end

  // Response register: one-cycle valid pulse, data/id held between responses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_txn;
      if (w_txn) begin
        r_id   <= id_i;
        r_data <= wen_i ? r_mem[w_idx] : '0;
      end
    end
  end

  // Saturating transaction and stall counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_n_rd    <= '0;
      r_n_wr    <= '0;
      r_n_stall <= '0;
    end else begin
      if (w_txn && wen_i && (r_n_rd != c_CNT_MAX)) begin
        r_n_rd <= r_n_rd + 32'd1;
      end
      if (w_txn && !wen_i && (r_n_wr != c_CNT_MAX)) begin
        r_n_wr <= r_n_wr + 32'd1;
      end
      if (req_i && !gnt_o && (r_n_stall != c_CNT_MAX)) begin
        r_n_stall <= r_n_stall + 32'd1;
      end
    end
  end

  assign r_valid_o = r_valid;
  assign r_data_o  = r_data;
  assign r_id_o    = r_id;
  assign n_rd_o    = r_n_rd;
  assign n_wr_o    = r_n_wr;
  assign n_stall_o = r_n_stall;

endmodule

`default_nettype wire

// File: tb/tb_hci_tcdm_bank_responder.sv
// ============================================================================
//  Module   : tb_hci_tcdm_bank_responder
//  Brief    : Directed self-checking bench with response scoreboard for
//             hci_tcdm_bank_responder (no-stall and stall instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hci_tcdm_bank_responder;

  typedef struct packed {
    logic [9:0]  id;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst_n;

  logic        clear, req, gnt, wen, r_valid;
  logic [10:0] add;
  logic [3:0]  be;
  logic [31:0] data, r_data, n_rd, n_wr, n_stall;
  logic [9:0]  id, r_id;

  logic        clear_s, req_s, gnt_s, wen_s, r_valid_s;
  logic [10:0] add_s;
  logic [3:0]  be_s;
  logic [31:0] data_s, r_data_s, n_rd_s, n_wr_s, n_stall_s;
  logic [9:0]  id_s, r_id_s;

  int          checks = 0;
  int          errors = 0;
  resp_t       sb [$];
  resp_t       mon_e;
  logic [31:0] model [512];
  logic [15:0] m_lfsr;
  logic        exp_g;
  int          grants;

  hci_tcdm_bank_responder #(.STALL_EN(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .gnt_o(gnt),
    .add_i(add), .wen_i(wen), .be_i(be), .data_i(data), .id_i(id),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_id_o(r_id),
    .n_rd_o(n_rd), .n_wr_o(n_wr), .n_stall_o(n_stall)
  );

  hci_tcdm_bank_responder #(.STALL_EN(1), .LFSR_SEED(16'hACE1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_s), .req_i(req_s), .gnt_o(gnt_s),
    .add_i(add_s), .wen_i(wen_s), .be_i(be_s), .data_i(data_s), .id_i(id_s),
    .r_valid_o(r_valid_s), .r_data_o(r_data_s), .r_id_o(r_id_s),
    .n_rd_o(n_rd_s), .n_wr_o(n_wr_s), .n_stall_o(n_stall_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Issue one transaction on the no-stall instance; called at posedge+1.
  task automatic txn(input logic w, input logic [10:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [9:0] tid);
    resp_t e;
    req = 1'b1; wen = w; add = a; be = b; data = d; id = tid; clear = 1'b0;
    #1;
    check("gnt", 64'(gnt), 64'(1'b1));
    e.id   = tid;
    e.data = w ? model[a[10:2]] : 32'h0;
    if (!w) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) model[a[10:2]][k*8 +: 8] = d[k*8 +: 8];
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic idle();
    req = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every valid response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && r_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 64'(r_valid), 64'(1'b0));
      end else begin
        mon_e = sb.pop_front();
        check("r_id", 64'(r_id), 64'(mon_e.id));
        check("r_data", 64'(r_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; req = 1'b0; wen = 1'b1; add = '0; be = '0; data = '0; id = '0;
    clear_s = 1'b0; req_s = 1'b0; wen_s = 1'b1; add_s = '0; be_s = '0; data_s = '0; id_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_valid", 64'(r_valid), 64'(1'b0));
    check("rst_r_data", 64'(r_data), 64'(32'h0));
    check("rst_r_id", 64'(r_id), 64'(10'h0));
    check("rst_n_rd", 64'(n_rd), 64'(32'h0));
    check("rst_n_wr", 64'(n_wr), 64'(32'h0));
    check("rst_n_stall", 64'(n_stall), 64'(32'h0));
    check("gnt_idle", 64'(gnt), 64'(1'b0));
    rst_n = 1'b1;

    // Write then read back, consecutive responses.
    txn(1'b0, 11'h010, 4'hF, 32'hDEADBEEF, 10'd3);
    txn(1'b1, 11'h010, 4'h0, 32'h0, 10'd5);
    idle();
    check("hold_r_valid", 64'(r_valid), 64'(1'b0));
    check("hold_r_data", 64'(r_data), 64'(32'hDEADBEEF));
    check("hold_r_id", 64'(r_id), 64'(10'd5));
    check("n_wr_1", 64'(n_wr), 64'(32'd1));
    check("n_rd_1", 64'(n_rd), 64'(32'd1));

    // Partial byte-enable write; read with byte-offset bits set.
    txn(1'b0, 11'h020, 4'hF, 32'h11223344, 10'd7);
    txn(1'b0, 11'h020, 4'b0101, 32'hAABBCCDD, 10'd8);
    txn(1'b1, 11'h020, 4'h0, 32'h0, 10'd9);
    txn(1'b1, 11'h023, 4'h0, 32'h0, 10'd10);
    idle();
    check("partial_word", 64'(r_data), 64'(32'h11BB33DD));

    // Clear counters, then back-to-back bursts of writes and reads.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_n_wr", 64'(n_wr), 64'(32'h0));
    for (int k = 0; k < 8; k++) txn(1'b0, 11'(11'h100 + k*4), 4'hF, $urandom, 10'(20 + k));
    for (int k = 0; k < 8; k++) txn(1'b1, 11'(11'h100 + k*4), 4'h0, 32'h0, 10'(40 + k));
    idle();
    check("burst_n_rd", 64'(n_rd), 64'(32'd8));
    check("burst_n_wr", 64'(n_wr), 64'(32'd8));
    check("burst_n_stall", 64'(n_stall), 64'(32'd0));
    check("burst_drained", 64'(sb.size()), 64'(0));

    // Clear with a response still pending and a request on the bus.
    txn(1'b0, 11'h030, 4'hF, 32'hCAFEF00D, 10'd50);
    req = 1'b1; wen = 1'b1; add = 11'h010; id = 10'd51; clear = 1'b1;
    #1;
    check("gnt_clear", 64'(gnt), 64'(1'b0));
    @(posedge clk);
    #1;
    clear = 1'b0; req = 1'b0;
    check("clr_r_valid", 64'(r_valid), 64'(1'b0));
    check("clr_n_rd", 64'(n_rd), 64'(32'h0));
    check("clr_n_wr2", 64'(n_wr), 64'(32'h0));
    check("clr_n_stall", 64'(n_stall), 64'(32'h0));
    txn(1'b1, 11'h010, 4'h0, 32'h0, 10'd52);
    txn(1'b1, 11'h030, 4'h0, 32'h0, 10'd53);
    idle();
    check("after_clear_data", 64'(r_data), 64'(32'hCAFEF00D));

    // Saturation: preload the write counter near the top.
    force dut.r_n_wr = 32'hFFFF_FFFE;
    #1;
    release dut.r_n_wr;
    check("preload_n_wr", 64'(n_wr), 64'(32'hFFFF_FFFE));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) txn(1'b0, 11'h040, 4'hF, 32'(k), 10'(60 + k));
    idle();
    check("sat_n_wr", 64'(n_wr), 64'(32'hFFFF_FFFF));

    // Stall instance: req held for 64 cycles against a reference LFSR.
    clear_s = 1'b1;
    @(posedge clk);
    #1;
    clear_s = 1'b0; req_s = 1'b1; wen_s = 1'b0; be_s = 4'hF;
    m_lfsr = 16'hACE1;
    grants = 0;
    for (int i = 0; i < 64; i++) begin
      add_s  = 11'(i * 4);
      data_s = 32'(i);
      id_s   = 10'(i);
      #1;
      exp_g = (m_lfsr[1:0] != 2'b00);
      check("stall_gnt", 64'(gnt_s), 64'(exp_g));
      if (exp_g) grants++;
      @(posedge clk);
      m_lfsr = lfsr_next(m_lfsr);
      #1;
    end
    req_s = 1'b0;
    check("stall_n_stall", 64'(n_stall_s), 64'(64 - grants));
    check("stall_n_wr", 64'(n_wr_s), 64'(grants));

    idle();
    idle();
    check("final_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
